// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: PC update mode codes and FSM states.
package fetch_seq_pkg;

  localparam logic [1:0] PC_NORMAL = 2'b11;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_UCJUMP = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_REDIR = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

endpackage

// File: rtl/fetch_wdog.sv
// 8-bit saturating wait counter; flags the cycle in which the count reaches LIMIT.
module fetch_wdog #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIM  = 8'(LIMIT);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else if (clr)
      count_reg <= '0;
    else if (en && count_reg != LIM)
      count_reg <= count_reg + 8'd1;
  end

  // Counter holds the number of completed wait cycles, so LIMIT is reached this cycle
  // when it currently reads LIMIT-1.
  assign expired = en && (count_reg == LAST);

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: one outstanding imem fetch, valid/ready issue to decode, and PC
// update control for sequential flow, branches, jumps and trap redirects.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  input  logic        br_take,
  input  logic [31:0] br_off,
  input  logic        jmp_take,
  input  logic [31:0] jmp_tgt,
  input  logic        trap_req,
  output logic [1:0]  pc_mode,
  output logic [31:0] pc_off,
  output logic [31:0] pc_tgt,
  output logic        pc_adv,
  output logic        fault
);

  state_t      state_reg, state_next;
  logic [31:0] inst_reg, inst_next;
  logic        pend_reg, pend_next;
  logic        fault_reg, fault_next;
  logic        wdog_clr, wdog_en, wdog_expired;

  fetch_wdog #(.LIMIT(WAIT_MAX)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  always_comb begin
    state_next = state_reg;
    inst_next  = inst_reg;
    pend_next  = pend_reg;
    fault_next = fault_reg;
    wdog_clr   = 1'b0;
    wdog_en    = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    pc_mode    = PC_NORMAL;
    pc_off     = '0;
    pc_tgt     = '0;
    pc_adv     = 1'b0;
    case (state_reg)
      ST_BOOT: state_next = ST_FETCH;
      ST_FETCH: begin
        if (trap_req) pend_next = 1'b1;
        if (pend_reg) begin
          state_next = ST_REDIR;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            state_next = ST_WAIT;
            wdog_clr   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        wdog_en = 1'b1;
        if (trap_req) pend_next = 1'b1;
        // A response always beats a timeout landing in the same cycle.
        if (imem_rvalid) begin
          if (pend_reg) begin
            state_next = ST_REDIR;
          end else begin
            inst_next  = imem_rdata;
            state_next = ST_ISSUE;
          end
        end else if (wdog_expired) begin
          fault_next = 1'b1;
          state_next = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        if (pend_reg || trap_req) begin
          state_next = ST_REDIR;
        end else begin
          inst_valid = 1'b1;
          if (inst_ready) begin
            pc_adv     = 1'b1;
            state_next = ST_FETCH;
            if (jmp_take) begin
              pc_mode = PC_UCJUMP;
              pc_tgt  = jmp_tgt;
            end else if (br_take) begin
              pc_mode = PC_BRANCH;
              pc_off  = br_off;
            end
          end
        end
      end
      ST_REDIR: begin
        pc_adv     = 1'b1;
        pc_mode    = PC_UCJUMP;
        pc_tgt     = TRAP_VEC;
        pend_next  = 1'b0;
        state_next = ST_FETCH;
      end
      ST_FAULT: ;
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
      inst_reg  <= '0;
      pend_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      inst_reg  <= inst_next;
      pend_reg  <= pend_next;
      fault_reg <= fault_next;
    end
  end

  assign inst  = inst_reg;
  assign fault = fault_reg;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed scenarios plus random traffic for fetch_seq, checked every cycle against a
// transaction-level model of the fetch/issue/redirect rules.
module tb_fetch_seq;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic        br_take, jmp_take, trap_req;
  logic [31:0] br_off, jmp_tgt;
  logic [1:0]  pc_mode;
  logic [31:0] pc_off, pc_tgt;
  logic        pc_adv, fault;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_seq #(.TRAP_VEC(TRAP_VEC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .br_take(br_take), .br_off(br_off), .jmp_take(jmp_take), .jmp_tgt(jmp_tgt),
    .trap_req(trap_req),
    .pc_mode(pc_mode), .pc_off(pc_off), .pc_tgt(pc_tgt), .pc_adv(pc_adv),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  // Model: what the sequencer is doing, in terms of the transaction in flight.
  logic        m_boot, m_out, m_hold, m_redir, m_pend, m_dead;
  int          m_waited;
  logic [31:0] m_word;

  // Last sampled DUT outputs, for directed checks.
  logic        o_req, o_valid, o_adv, o_fault;
  logic [1:0]  o_mode;
  logic [31:0] o_off, o_tgt, o_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_out = 1'b0; m_hold = 1'b0; m_redir = 1'b0;
    m_pend = 1'b0; m_dead = 1'b0; m_waited = 0; m_word = '0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic        e_req, e_valid, e_adv;
    logic [1:0]  e_mode;
    logic [31:0] e_off, e_tgt;
    @(negedge clk);
    e_req = 1'b0; e_valid = 1'b0; e_adv = 1'b0;
    e_mode = 2'b11; e_off = '0; e_tgt = '0;
    if (rst) begin
      model_reset();
    end else if (m_dead || m_boot) begin
      // idle
    end else if (m_redir) begin
      e_adv = 1'b1; e_mode = 2'b10; e_tgt = TRAP_VEC;
    end else if (m_hold) begin
      if (!(m_pend || trap_req)) begin
        e_valid = 1'b1;
        if (inst_ready) begin
          e_adv = 1'b1;
          if (jmp_take) begin
            e_mode = 2'b10; e_tgt = jmp_tgt;
          end else if (br_take) begin
            e_mode = 2'b01; e_off = br_off;
          end
        end
      end
    end else if (!m_out) begin
      e_req = !m_pend;
    end
    chk("imem_req", imem_req, e_req);
    chk("inst_valid", inst_valid, e_valid);
    chk("inst", inst, m_word);
    chk("pc_adv", pc_adv, e_adv);
    chk("pc_mode", pc_mode, e_mode);
    chk("pc_off", pc_off, e_off);
    chk("pc_tgt", pc_tgt, e_tgt);
    chk("fault", fault, m_dead);
    o_req = imem_req; o_valid = inst_valid; o_adv = pc_adv; o_fault = fault;
    o_mode = pc_mode; o_off = pc_off; o_tgt = pc_tgt; o_inst = inst;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_dead) begin
      // only reset leaves a fault
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_redir) begin
      m_redir = 1'b0; m_pend = 1'b0;
    end else if (m_hold) begin
      if (m_pend || trap_req) begin
        m_hold = 1'b0; m_redir = 1'b1;
      end else if (inst_ready) begin
        m_hold = 1'b0;
      end
    end else if (m_out) begin
      m_waited++;
      if (imem_rvalid) begin
        m_out = 1'b0;
        if (m_pend) m_redir = 1'b1;
        else begin m_word = imem_rdata; m_hold = 1'b1; end
      end else if (m_waited == WAIT_MAX) begin
        m_dead = 1'b1;
      end
      if (trap_req) m_pend = 1'b1;
    end else begin
      if (m_pend) m_redir = 1'b1;
      else if (imem_gnt) begin m_out = 1'b1; m_waited = 0; end
      if (trap_req) m_pend = 1'b1;
    end
    #1;
  endtask

  initial begin
    int first_valid;
    logic [1:0] first_mode;
    int adv_count, valid_count;
    logic [31:0] hold_word;

    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
    br_take = 0; br_off = '0; jmp_take = 0; jmp_tgt = '0; trap_req = 0;
    model_reset();
    #1;
    step(); step();
    rst = 1'b0;

    // 1: first instruction latency and sequential PC update
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h1111_0001; inst_ready = 1;
    first_valid = -1; first_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_valid && first_valid < 0) first_valid = i;
      if (o_adv && first_mode == 2'b00) first_mode = o_mode;
    end
    chk("t1_latency", first_valid, 3);
    chk("t1_first_mode", first_mode, 2'b11);

    // 2: taken branch
    br_take = 1; br_off = 32'hFFFF_FFF8; imem_rdata = 32'h2222_0002;
    adv_count = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_adv) adv_count++;
    end
    chk("t2_mode", o_mode, 2'b01);
    chk("t2_off", o_off, 32'hFFFF_FFF8);
    chk("t2_adv_cycles", adv_count, 1);

    // 3: jump beats branch
    jmp_take = 1; jmp_tgt = 32'h0000_2000; imem_rdata = 32'h3333_0003;
    for (int i = 0; i < 3; i++) step();
    chk("t3_mode", o_mode, 2'b10);
    chk("t3_tgt", o_tgt, 32'h0000_2000);
    chk("t3_off", o_off, 32'h0);
    br_take = 0; jmp_take = 0;

    // 4: trap while waiting drops the word and redirects
    valid_count = 0;
    imem_gnt = 1; imem_rvalid = 0; step(); if (o_valid) valid_count++;
    imem_gnt = 0; trap_req = 1;    step(); if (o_valid) valid_count++;
    trap_req = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_0004;
    step(); if (o_valid) valid_count++;
    imem_rvalid = 0; step(); if (o_valid) valid_count++;
    chk("t4_valid_cycles", valid_count, 0);
    chk("t4_redir_tgt", o_tgt, TRAP_VEC);
    chk("t4_redir_mode", o_mode, 2'b10);
    chk("t4_redir_adv", o_adv, 1'b1);

    // 5a: response in the last allowed wait cycle is still accepted
    imem_gnt = 1; step(); imem_gnt = 0;
    for (int i = 0; i < WAIT_MAX - 1; i++) step();
    imem_rvalid = 1; imem_rdata = 32'h5555_0005; step(); imem_rvalid = 0;
    step();
    chk("t5_late_valid", o_valid, 1'b1);
    chk("t5_late_inst", o_inst, 32'h5555_0005);
    inst_ready = 1; step();
    // 5b: no response at all -> timeout fault
    imem_gnt = 1; step(); imem_gnt = 0;
    for (int i = 0; i < WAIT_MAX; i++) step();
    imem_gnt = 1; imem_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_fault", o_fault, 1'b1);
      chk("t5_req_idle", o_req, 1'b0);
    end
    rst = 1; step(); rst = 0;
    chk("t5_fault_cleared", o_fault, 1'b0);

    // 6: decode stall holds the instruction
    inst_ready = 0; imem_rdata = 32'h6666_0006;
    step(); step(); step();
    imem_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_valid", o_valid, 1'b1);
      chk("t6_inst", o_inst, 32'h6666_0006);
      chk("t6_adv", o_adv, 1'b0);
      chk("t6_req", o_req, 1'b0);
    end
    inst_ready = 1; step();

    // Random traffic, including occasional resets
    for (int i = 0; i < 3000; i++) begin
      imem_gnt    = ($urandom_range(0, 1) == 1);
      imem_rvalid = ($urandom_range(0, 2) != 0);
      imem_rdata  = $urandom;
      inst_ready  = ($urandom_range(0, 2) != 0);
      br_take     = ($urandom_range(0, 1) == 1);
      br_off      = $urandom;
      jmp_take    = ($urandom_range(0, 3) == 0);
      jmp_tgt     = $urandom;
      trap_req    = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
